// File: rtl/mgt_01_div_sequencer_pkg.sv
// Shared types and constants for the divider sequencer: op encoding, FU state,
// sequencer FSM states and default widths.
package mgt_01_div_sequencer_pkg;

  typedef enum logic [1:0] {
    DIV_  = 2'd0,
    DIVU_ = 2'd1,
    REM_  = 2'd2,
    REMU_ = 2'd3
  } div_ops_e;

  typedef enum logic {
    FREE = 1'b0,
    BUSY = 1'b1
  } fu_state_e;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StFix,
    StDone
  } div_seq_state_e;

  localparam int unsigned XLEN_DEFAULT        = 32;
  localparam logic [XLEN_DEFAULT-1:0] XLEN_MIN = {1'b1, {(XLEN_DEFAULT-1){1'b0}}};
  localparam int unsigned WDOG_MARGIN         = 4;
  localparam int unsigned WDOG_CYCLES_DEFAULT = XLEN_DEFAULT + WDOG_MARGIN;

  function automatic logic op_is_signed(div_ops_e op);
    return (op == DIV_) || (op == REM_);
  endfunction

  function automatic logic op_is_rem(div_ops_e op);
    return (op == REM_) || (op == REMU_);
  endfunction

endpackage

// File: rtl/mgt_01_div_sequencer_if.sv
// Request/result handshake bundle between the execute stage and the divider sequencer.
interface mgt_01_div_sequencer_if
  import mgt_01_div_sequencer_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
);
  logic            req_valid;
  logic            req_ready;
  div_ops_e        req_op;
  logic [XLEN-1:0] req_dividend;
  logic [XLEN-1:0] req_divisor;
  logic            res_valid;
  logic            res_ready;
  logic [XLEN-1:0] res_data;
  logic            res_err;

  modport master (
    output req_valid, req_op, req_dividend, req_divisor, res_ready,
    input  req_ready, res_valid, res_data, res_err
  );

  modport slave (
    input  req_valid, req_op, req_dividend, req_divisor, res_ready,
    output req_ready, res_valid, res_data, res_err
  );
endinterface

// File: rtl/mgt_01_div_special_case.sv
// Combinational request screen: flags divide-by-zero and signed overflow, forms their
// direct results, and produces unsigned operand magnitudes for the datapath.
module mgt_01_div_special_case
  import mgt_01_div_sequencer_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  div_ops_e        op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            zero_o,
  output logic            ovf_o,
  output logic            dvd_neg_o,
  output logic            dvs_neg_o,
  output logic [XLEN-1:0] special_data_o,
  output logic [XLEN-1:0] dvd_mag_o,
  output logic [XLEN-1:0] dvs_mag_o
);
  localparam logic [XLEN-1:0] MinVal = {1'b1, {(XLEN-1){1'b0}}};

  logic is_signed;
  logic is_rem;

  always_comb begin
    is_signed = op_is_signed(op_i);
    is_rem    = op_is_rem(op_i);
    dvd_neg_o = is_signed & dividend_i[XLEN-1];
    dvs_neg_o = is_signed & divisor_i[XLEN-1];
    dvd_mag_o = dvd_neg_o ? -dividend_i : dividend_i;
    dvs_mag_o = dvs_neg_o ? -divisor_i : divisor_i;
    zero_o    = (divisor_i == '0);
    ovf_o     = is_signed & (dividend_i == MinVal) & (divisor_i == '1);
    special_data_o = '0;
    if (zero_o) begin
      special_data_o = is_rem ? dividend_i : '1;
    end else if (ovf_o) begin
      special_data_o = is_rem ? '0 : MinVal;
    end
  end
endmodule

// File: rtl/mgt_01_div_sequencer.sv
// Divider sequencer: screens special cases, drives the radix-2 datapath, applies sign fix-up
// and holds the result for writeback. MGT_01_DIV_REM_FUSE_EN adds a one-entry div/rem reuse.
module mgt_01_div_sequencer
  import mgt_01_div_sequencer_pkg::*;
#(
  parameter int unsigned XLEN        = XLEN_DEFAULT,
  parameter int unsigned WDOG_CYCLES = XLEN + WDOG_MARGIN
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   clk_en_i,
  input  logic                   flush_i,
  mgt_01_div_sequencer_if.slave  bus,
  output fu_state_e              fu_state_o,
  output logic                   div_start_o,
  output logic                   div_abort_o,
  output logic [XLEN-1:0]        div_dividend_o,
  output logic [XLEN-1:0]        div_divisor_o,
  input  logic                   div_done_i,
  input  logic [XLEN-1:0]        div_quotient_i,
  input  logic [XLEN-1:0]        div_remainder_i
);
  localparam int unsigned CntW = $clog2(WDOG_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(WDOG_CYCLES - 1);

  div_seq_state_e  state_q;
  div_ops_e        op_q;
  logic            dvd_neg_q, dvs_neg_q;
  logic [XLEN-1:0] quo_q, rem_q;
  logic [CntW-1:0] cnt_q;
  logic            res_valid_q, res_err_q, start_q, abort_q;
  logic [XLEN-1:0] res_data_q, dvd_mag_q, dvs_mag_q;

  logic            sc_zero, sc_ovf, sc_special, sc_dvd_neg, sc_dvs_neg;
  logic [XLEN-1:0] sc_data, sc_dvd_mag, sc_dvs_mag;
  logic            accept, wdog_fire, fuse_hit;
  logic [XLEN-1:0] quo_fix, rem_fix, fix_data, fuse_data;

  mgt_01_div_special_case #(
    .XLEN (XLEN)
  ) u_special_case (
    .op_i           (bus.req_op),
    .dividend_i     (bus.req_dividend),
    .divisor_i      (bus.req_divisor),
    .zero_o         (sc_zero),
    .ovf_o          (sc_ovf),
    .dvd_neg_o      (sc_dvd_neg),
    .dvs_neg_o      (sc_dvs_neg),
    .special_data_o (sc_data),
    .dvd_mag_o      (sc_dvd_mag),
    .dvs_mag_o      (sc_dvs_mag)
  );

  assign bus.req_ready = (state_q == StIdle);
  assign accept        = bus.req_valid & bus.req_ready & clk_en_i & ~flush_i;
  assign sc_special    = sc_zero | sc_ovf;
  assign wdog_fire     = (state_q == StWait) & ~div_done_i & (cnt_q == CntLast);

  // Sign flags are already zero for unsigned ops, so no extra op gating is needed.
  always_comb begin
    quo_fix  = (dvd_neg_q ^ dvs_neg_q) ? -quo_q : quo_q;
    rem_fix  = dvd_neg_q ? -rem_q : rem_q;
    fix_data = op_is_rem(op_q) ? rem_fix : quo_fix;
  end

`ifdef MGT_01_DIV_REM_FUSE_EN
  logic            fuse_vld_q, fuse_signed_q;
  logic [XLEN-1:0] fuse_dvd_q, fuse_dvs_q, fuse_quo_q, fuse_rem_q, pend_dvd_q, pend_dvs_q;

  always_comb begin
    fuse_hit  = fuse_vld_q & (fuse_dvd_q == bus.req_dividend) & (fuse_dvs_q == bus.req_divisor) &
                (fuse_signed_q == op_is_signed(bus.req_op));
    fuse_data = op_is_rem(bus.req_op) ? fuse_rem_q : fuse_quo_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fuse_vld_q    <= 1'b0;
      fuse_signed_q <= 1'b0;
      fuse_dvd_q    <= '0;
      fuse_dvs_q    <= '0;
      fuse_quo_q    <= '0;
      fuse_rem_q    <= '0;
      pend_dvd_q    <= '0;
      pend_dvs_q    <= '0;
    end else if (clk_en_i) begin
      if (flush_i || wdog_fire || (accept && sc_special)) begin
        fuse_vld_q <= 1'b0;
      end else if (state_q == StFix) begin
        fuse_vld_q    <= 1'b1;
        fuse_signed_q <= op_is_signed(op_q);
        fuse_dvd_q    <= pend_dvd_q;
        fuse_dvs_q    <= pend_dvs_q;
        fuse_quo_q    <= quo_fix;
        fuse_rem_q    <= rem_fix;
      end
      if (accept) begin
        pend_dvd_q <= bus.req_dividend;
        pend_dvs_q <= bus.req_divisor;
      end
    end
  end
`else
  assign fuse_hit  = 1'b0;
  assign fuse_data = '0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= StIdle;
      op_q        <= DIV_;
      dvd_neg_q   <= 1'b0;
      dvs_neg_q   <= 1'b0;
      quo_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
      res_data_q  <= '0;
      start_q     <= 1'b0;
      abort_q     <= 1'b0;
      dvd_mag_q   <= '0;
      dvs_mag_q   <= '0;
    end else if (clk_en_i) begin
      start_q <= 1'b0;
      abort_q <= 1'b0;
      if (flush_i) begin
        state_q     <= StIdle;
        res_valid_q <= 1'b0;
        res_err_q   <= 1'b0;
        abort_q     <= (state_q == StWait);
      end else begin
        case (state_q)
          StIdle: begin
            if (accept) begin
              op_q      <= bus.req_op;
              dvd_neg_q <= sc_dvd_neg;
              dvs_neg_q <= sc_dvs_neg;
              res_err_q <= 1'b0;
              if (sc_special) begin
                state_q     <= StDone;
                res_valid_q <= 1'b1;
                res_data_q  <= sc_data;
              end else if (fuse_hit) begin
                state_q     <= StDone;
                res_valid_q <= 1'b1;
                res_data_q  <= fuse_data;
              end else begin
                state_q   <= StIssue;
                start_q   <= 1'b1;
                dvd_mag_q <= sc_dvd_mag;
                dvs_mag_q <= sc_dvs_mag;
              end
            end
          end
          StIssue: begin
            state_q <= StWait;
            cnt_q   <= '0;
          end
          StWait: begin
            if (div_done_i) begin
              quo_q   <= div_quotient_i;
              rem_q   <= div_remainder_i;
              state_q <= StFix;
            end else if (wdog_fire) begin
              abort_q     <= 1'b1;
              res_err_q   <= 1'b1;
              res_data_q  <= '0;
              res_valid_q <= 1'b1;
              state_q     <= StDone;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StFix: begin
            res_data_q  <= fix_data;
            res_valid_q <= 1'b1;
            state_q     <= StDone;
          end
          StDone: begin
            if (bus.res_ready) begin
              res_valid_q <= 1'b0;
              res_err_q   <= 1'b0;
              state_q     <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // Pulses only ever appear on enabled cycles, even if the enable drops while one is pending.
  assign div_start_o    = start_q & clk_en_i;
  assign div_abort_o    = abort_q & clk_en_i;
  assign div_dividend_o = dvd_mag_q;
  assign div_divisor_o  = dvs_mag_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_err    = res_err_q;
  assign fu_state_o     = (state_q == StIdle) ? FREE : BUSY;
endmodule

// File: tb/tb_mgt_01_div_sequencer.sv
// Scoreboard bench for mgt_01_div_sequencer with a behavioural radix-2 datapath stand-in.
module tb_mgt_01_div_sequencer;
  import mgt_01_div_sequencer_pkg::*;

  localparam int unsigned XLEN = XLEN_DEFAULT;
  localparam int unsigned WDOG = WDOG_CYCLES_DEFAULT;
`ifdef MGT_01_DIV_REM_FUSE_EN
  localparam bit FuseEn = 1'b1;
`else
  localparam bit FuseEn = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_n_i, clk_en_i, flush_i;
  fu_state_e       fu_state_o;
  logic            div_start_o, div_abort_o, div_done_i;
  logic [XLEN-1:0] div_dividend_o, div_divisor_o, div_quotient_i, div_remainder_i;

  mgt_01_div_sequencer_if #(.XLEN(XLEN)) bus ();

  mgt_01_div_sequencer #(
    .XLEN        (XLEN),
    .WDOG_CYCLES (WDOG)
  ) dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .clk_en_i        (clk_en_i),
    .flush_i         (flush_i),
    .bus             (bus),
    .fu_state_o      (fu_state_o),
    .div_start_o     (div_start_o),
    .div_abort_o     (div_abort_o),
    .div_dividend_o  (div_dividend_o),
    .div_divisor_o   (div_divisor_o),
    .div_done_i      (div_done_i),
    .div_quotient_i  (div_quotient_i),
    .div_remainder_i (div_remainder_i)
  );

  always #5 clk_i = ~clk_i;

  exp_t        sb[$];
  int          n_tests = 0, n_fail = 0;
  int          cyc = 0, rise_cyc = 0, start_cnt = 0, abort_cnt = 0;
  int          dp_due = 0, dp_lat = 0;
  bit          dp_busy = 1'b0, dp_silent = 1'b0, prev_valid = 1'b0;
  logic [31:0] dp_a = '0, dp_b = 32'd1, exp_ma = '0, exp_mb = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req_v);
    n_tests++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req_v);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  // Datapath stand-in: returns unsigned results dp_lat cycles after the start cycle.
  always @(posedge clk_i) begin
    #1;
    div_done_i = 1'b0;
    if (dp_busy && !dp_silent && cyc == dp_due) begin
      div_done_i      = 1'b1;
      div_quotient_i  = dp_a / dp_b;
      div_remainder_i = dp_a % dp_b;
      dp_busy         = 1'b0;
    end
  end

  // Monitor: sees datapath traffic and pops the scoreboard on every result handshake.
  always @(negedge clk_i) begin
    exp_t e;
    if (bus.res_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = bus.res_valid;
    if (div_start_o) begin
      start_cnt++;
      dp_busy = 1'b1;
      dp_due  = cyc + dp_lat;
      dp_a    = div_dividend_o;
      dp_b    = div_divisor_o;
      check("start dividend magnitude", div_dividend_o, exp_ma);
      check("start divisor magnitude", div_divisor_o, exp_mb);
    end
    if (div_abort_o) begin
      abort_cnt++;
      dp_busy = 1'b0;
    end
    if (bus.res_valid && bus.res_ready && clk_en_i && !flush_i) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected result: got 0x%08h, expected none", bus.res_data);
      end else begin
        e = sb.pop_front();
        check({e.name, " data"}, bus.res_data, e.data);
        check({e.name, " err"}, bus.res_err, e.err);
        check({e.name, " latency"}, rise_cyc - e.acc, e.lat);
      end
    end
  end

  task automatic issue(input string name, input div_ops_e op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input logic err,
                       input int lat, input int d, input logic [31:0] ma, input logic [31:0] mb,
                       input bit push);
    int t;
    t = 0;
    while (!bus.req_ready && t < 100) begin
      step();
      t++;
    end
    check({name, " ready before issue"}, bus.req_ready, 1);
    dp_lat           = d;
    exp_ma           = ma;
    exp_mb           = mb;
    bus.req_valid    = 1'b1;
    bus.req_op       = op;
    bus.req_dividend = a;
    bus.req_divisor  = b;
    if (push) sb.push_back('{name, res, err, cyc, lat});
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      step();
      t++;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout: got no result in 200 cycles, expected one", name);
      sb.delete();
    end
  endtask

  task automatic run_vec(input string name, input div_ops_e op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input logic [31:0] ma,
                         input logic [31:0] mb, input bit special, input bit fuse, input int d);
    bit short_path;
    int s0;
    short_path = special || (FuseEn && fuse);
    s0         = start_cnt;
    issue(name, op, a, b, res, 1'b0, short_path ? 1 : 3 + d, d, ma, mb, 1'b1);
    drain(name);
    check({name, " start pulses"}, start_cnt - s0, short_path ? 0 : 1);
  endtask

  initial begin
    #400000;
    $display("FAIL global timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int a0, s0, hi;
    rst_n_i = 1'b0; clk_en_i = 1'b1; flush_i = 1'b0;
    bus.req_valid = 1'b0; bus.req_op = DIV_; bus.req_dividend = '0; bus.req_divisor = '0;
    bus.res_ready = 1'b1;
    div_done_i = 1'b0; div_quotient_i = '0; div_remainder_i = '0;
    repeat (2) @(negedge clk_i);
    check("reset req_ready", bus.req_ready, 1);
    check("reset res_valid", bus.res_valid, 0);
    check("reset res_err", bus.res_err, 0);
    check("reset res_data", bus.res_data, 0);
    check("reset fu_state", fu_state_o, FREE);
    check("reset start", div_start_o, 0);
    check("reset abort", div_abort_o, 0);
    check("reset dividend mag", div_dividend_o, 0);
    check("reset divisor mag", div_divisor_o, 0);
    rst_n_i = 1'b1;
    step();

    run_vec("divu 100/7", DIVU_, 100, 7, 14, 100, 7, 0, 0, 33);
    run_vec("remu 100/7", REMU_, 100, 7, 2, 100, 7, 0, 1, 33);
    run_vec("div -7/2", DIV_, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD, 7, 2, 0, 0, 5);
    run_vec("rem -7/2", REM_, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF, 7, 2, 0, 1, 5);
    run_vec("rem 7/-2", REM_, 7, 32'hFFFF_FFFE, 1, 7, 2, 0, 0, 3);
    run_vec("div 100/-7", DIV_, 100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 100, 7, 0, 0, 2);
    run_vec("divu 5/0", DIVU_, 5, 0, 32'hFFFF_FFFF, 0, 0, 1, 0, 0);
    run_vec("rem 5/0", REM_, 5, 0, 5, 0, 0, 1, 0, 0);
    run_vec("div min/-1", DIV_, XLEN_MIN, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0, 1, 0, 0);
    run_vec("rem min/-1", REM_, XLEN_MIN, 32'hFFFF_FFFF, 0, 0, 0, 1, 0, 0);
    run_vec("pair div 100/7", DIV_, 100, 7, 14, 100, 7, 0, 0, 4);
    run_vec("pair rem 100/7", REM_, 100, 7, 2, 100, 7, 0, 1, 4);

    // Result held while writeback stalls.
    bus.res_ready = 1'b0;
    issue("hold divu 5/0", DIVU_, 5, 0, 32'hFFFF_FFFF, 1'b0, 1, 0, 0, 0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check("hold res_valid", bus.res_valid, 1);
      check("hold res_data", bus.res_data, 32'hFFFF_FFFF);
      check("hold req_ready", bus.req_ready, 0);
      step();
    end
    bus.res_ready = 1'b1;
    drain("hold divu 5/0");

    // Flush in the tenth WAIT cycle.
    issue("flush divu", DIVU_, 100, 7, 0, 1'b0, 0, 40, 100, 7, 1'b0);
    repeat (10) step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    @(negedge clk_i);
    check("flush abort pulse", div_abort_o, 1);
    check("flush req_ready", bus.req_ready, 1);
    check("flush res_valid", bus.res_valid, 0);
    check("flush fu_state", fu_state_o, FREE);
    step();
    @(negedge clk_i);
    check("flush abort single", div_abort_o, 0);
    hi = 0;
    for (int i = 0; i < 45; i++) begin
      step();
      @(negedge clk_i);
      if (bus.res_valid) hi++;
    end
    check("flush no result cycles", hi, 0);
    step();

    // Silent datapath trips the watchdog.
    dp_silent = 1'b1;
    a0 = abort_cnt;
    s0 = start_cnt;
    issue("watchdog", DIVU_, 100, 7, 0, 1'b1, WDOG + 2, 10, 100, 7, 1'b1);
    drain("watchdog");
    check("watchdog abort pulses", abort_cnt - a0, 1);
    check("watchdog start pulses", start_cnt - s0, 1);

    // Three disabled cycles mid-WAIT push the abort out by three.
    a0 = abort_cnt;
    issue("freeze", DIVU_, 100, 7, 0, 1'b1, WDOG + 5, 10, 100, 7, 1'b1);
    repeat (5) step();
    clk_en_i = 1'b0;
    repeat (3) step();
    clk_en_i = 1'b1;
    drain("freeze");
    check("freeze abort pulses", abort_cnt - a0, 1);
    dp_silent = 1'b0;

    run_vec("after abort divu 9/4", DIVU_, 9, 4, 2, 9, 4, 0, 0, 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
